// File: rtl/cache_pkg.sv
// Shared defaults, write-way selection encoding and LRU age helpers for the
// set-associative line store.
package cache_pkg;

    localparam int unsigned DEF_NUM_SETS = 16;
    localparam int unsigned DEF_NUM_WAYS = 2;
    localparam int unsigned DEF_TAG_W    = 8;
    localparam int unsigned DEF_DATA_W   = 64;

    typedef enum logic [1:0] {
        SEL_HIT,
        SEL_FREE,
        SEL_VICTIM
    } wr_sel_e;

    // Ages younger than the accessed way grow older by one; the accessed way becomes youngest.
    function automatic int unsigned lru_age_next(input int unsigned age,
                                                 input int unsigned acc_age,
                                                 input logic        is_acc);
        if (is_acc)
            return 0;
        if (age < acc_age)
            return age + 1;
        return age;
    endfunction

    function automatic logic lru_is_victim(input int unsigned age,
                                           input int unsigned num_ways);
        return age == num_ways - 1;
    endfunction

endpackage

// File: rtl/cachemem_lru.sv
// Per-set true-LRU age tracker: one age per way, always a permutation of
// 0..NUM_WAYS-1; the oldest way is reported as the replacement victim.
module cachemem_lru
    import cache_pkg::*;
#(
    parameter  int unsigned NUM_WAYS = DEF_NUM_WAYS,
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             acc_en,
    input  logic [WAY_W-1:0] acc_way,
    output logic [WAY_W-1:0] victim_way
);

    logic [WAY_W-1:0] age [NUM_WAYS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++)
                age[w] <= WAY_W'(w);
        end else if (acc_en) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++)
                age[w] <= WAY_W'(lru_age_next(32'(age[w]), 32'(age[acc_way]),
                                              acc_way == WAY_W'(w)));
        end
    end

    always_comb begin
        victim_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++)
            if (lru_is_victim(32'(age[w]), NUM_WAYS))
                victim_way = WAY_W'(w);
    end

endmodule

// File: rtl/cachemem_assoc.sv
// Set-associative line store with per-set LRU replacement, invalidate, and a
// registered one-cycle writeback pulse for dirty lines that leave the store.
module cachemem_assoc
    import cache_pkg::*;
#(
    parameter  int unsigned NUM_SETS = DEF_NUM_SETS,
    parameter  int unsigned NUM_WAYS = DEF_NUM_WAYS,
    parameter  int unsigned TAG_W    = DEF_TAG_W,
    parameter  int unsigned DATA_W   = DEF_DATA_W,
    localparam int unsigned IDX_W    = $clog2(NUM_SETS),
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_dirty,
    input  logic              inv_en,
    input  logic [IDX_W-1:0]  inv_idx,
    input  logic [TAG_W-1:0]  inv_tag,
    output logic              evict_valid,
    output logic [TAG_W-1:0]  evict_tag,
    output logic [IDX_W-1:0]  evict_idx,
    output logic [DATA_W-1:0] evict_data
);

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid, dirty;
    logic [TAG_W-1:0]  tag_mem  [NUM_SETS][NUM_WAYS];
    logic [DATA_W-1:0] data_mem [NUM_SETS][NUM_WAYS];

    logic [WAY_W-1:0]    victim_way [NUM_SETS];
    logic [WAY_W-1:0]    acc_way    [NUM_SETS];
    logic [NUM_SETS-1:0] acc_en;

    int unsigned      rd_hits;
    logic [WAY_W-1:0] rd_way;
    wr_sel_e          wr_sel;
    logic [WAY_W-1:0] wr_way, hit_way, free_way, inv_way, ev_way;
    logic             wr_hit, wr_free, inv_hit, inv_go, ev_now, evict_q;
    logic [IDX_W-1:0] ev_idx;

    always_comb begin
        rd_hits = 0;
        rd_way  = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++)
            if (valid[rd_idx][w] && tag_mem[rd_idx][w] == rd_tag) begin
                rd_hits++;
                rd_way = WAY_W'(w);
            end
    end

    assign rd_valid = (rd_hits == 1);
    assign rd_data  = data_mem[rd_idx][rd_way];

    always_comb begin
        wr_hit   = 1'b0;
        wr_free  = 1'b0;
        hit_way  = '0;
        free_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!wr_hit && valid[wr_idx][w] && tag_mem[wr_idx][w] == wr_tag) begin
                wr_hit  = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!wr_free && !valid[wr_idx][w]) begin
                wr_free  = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        if (wr_hit) begin
            wr_sel = SEL_HIT;
            wr_way = hit_way;
        end else if (wr_free) begin
            wr_sel = SEL_FREE;
            wr_way = free_way;
        end else begin
            wr_sel = SEL_VICTIM;
            wr_way = victim_way[wr_idx];
        end
    end

    // A write takes the access slot of its set; reads only touch LRU on a hit.
    always_comb begin
        for (int unsigned s = 0; s < NUM_SETS; s++) begin
            acc_en[s]  = 1'b0;
            acc_way[s] = rd_way;
            if (wr_en && wr_idx == IDX_W'(s)) begin
                acc_en[s]  = 1'b1;
                acc_way[s] = wr_way;
            end else if (rd_en && rd_valid && rd_idx == IDX_W'(s)) begin
                acc_en[s] = 1'b1;
            end
        end
    end

    always_comb begin
        inv_hit = 1'b0;
        inv_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++)
            if (!inv_hit && valid[inv_idx][w] && tag_mem[inv_idx][w] == inv_tag) begin
                inv_hit = 1'b1;
                inv_way = WAY_W'(w);
            end
        inv_go = inv_en && !wr_en && inv_hit;
        ev_now = 1'b0;
        ev_way = wr_way;
        ev_idx = wr_idx;
        if (wr_en) begin
            ev_now = (wr_sel == SEL_VICTIM) && valid[wr_idx][wr_way] && dirty[wr_idx][wr_way];
        end else if (inv_go) begin
            ev_now = dirty[inv_idx][inv_way];
            ev_way = inv_way;
            ev_idx = inv_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid   <= '0;
            dirty   <= '0;
            evict_q <= 1'b0;
        end else begin
            evict_q <= ev_now;
            if (wr_en) begin
                valid[wr_idx][wr_way] <= 1'b1;
                dirty[wr_idx][wr_way] <= wr_dirty | ((wr_sel == SEL_HIT) & dirty[wr_idx][wr_way]);
            end else if (inv_go) begin
                valid[inv_idx][inv_way] <= 1'b0;
                dirty[inv_idx][inv_way] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ev_now) begin
            evict_tag  <= tag_mem[ev_idx][ev_way];
            evict_idx  <= ev_idx;
            evict_data <= data_mem[ev_idx][ev_way];
        end
        if (wr_en && !reset) begin
            tag_mem[wr_idx][wr_way]  <= wr_tag;
            data_mem[wr_idx][wr_way] <= wr_data;
        end
    end

    // Gating with reset drops a writeback that is due in the same cycle reset arrives.
    assign evict_valid = evict_q && !reset;

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        cachemem_lru #(
            .NUM_WAYS (NUM_WAYS)
        ) u_lru (
            .clock      (clock),
            .reset      (reset),
            .acc_en     (acc_en[s]),
            .acc_way    (acc_way[s]),
            .victim_way (victim_way[s])
        );
    end

endmodule

// File: doc/cachemem_assoc.md
CACHEMEM_ASSOC -- requirements
Module: cachemem_assoc

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16, number of sets (power of 2, ≥2); IDX_W = log2(NUM_SETS).
REQ-002 SHALL have parameter NUM_WAYS, default 2, associativity (power of 2, ≥2); WAY_W = log2(NUM_WAYS).
REQ-003 SHALL have parameter TAG_W, default 8, tag width.
REQ-004 SHALL have parameter DATA_W, default 64, line data width.
REQ-005 clock  in  1  single clock; all state updates on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rd_idx / rd_tag  in  IDX_W / TAG_W  lookup set and tag.
REQ-008 rd_en  in  1  lookup counts as an access for LRU.
REQ-009 rd_data / rd_valid  out  DATA_W / 1  hit data and hit flag, combinational.
REQ-010 wr_en, wr_idx, wr_tag, wr_data, wr_dirty  in  1 / IDX_W / TAG_W / DATA_W / 1  line fill or update.
REQ-011 inv_en, inv_idx, inv_tag  in  1 / IDX_W / TAG_W  invalidate request.
REQ-012 evict_valid, evict_tag, evict_idx, evict_data  out  1 / TAG_W / IDX_W / DATA_W  registered dirty-line writeback.

Function
REQ-013 rd_valid SHALL be 1 iff exactly one valid way in set rd_idx has tag == rd_tag; rd_data = that way's data, else don't-care.
REQ-014 Each set SHALL hold per-way valid, dirty, tag, data and a WAY_W-bit age; ages in a set are always a permutation of 0..NUM_WAYS-1.
REQ-015 Access update: accessed way age <- 0; every way with age below its old age increments; others unchanged.
REQ-016 rd_en with rd_valid SHALL apply the access update to set rd_idx at the edge; a miss changes nothing.
REQ-017 Write way selection, in priority: valid way with matching tag; else lowest-numbered invalid way; else way with age NUM_WAYS-1 (victim).
REQ-018 Write SHALL set valid=1, tag, data; dirty <- wr_dirty if filling a new way, dirty <- old dirty OR wr_dirty on tag match; then access update on that way.
REQ-019 Replacing a valid dirty victim SHALL drive evict_valid=1 for exactly the following cycle with victim's old tag, idx and data.
REQ-020 inv_en SHALL be serviced only when wr_en=0; if ignored it is dropped, not queued.
REQ-021 Serviced invalidate with matching valid way: valid <- 0, dirty <- 0, ages unchanged; if that way was dirty, evict_* pulses next cycle as in REQ-019; no match: no effect.
REQ-022 Read and write to the same set in one cycle: rd_* reflect pre-edge contents; only the write's access update is applied.
REQ-023 evict_valid SHALL be 0 in every cycle not following a dirty replacement or dirty invalidate; at most one eviction per cycle by construction.
REQ-024 Write latency: rd_* reflect a write one cycle after the wr_en edge; no combinational write-to-read bypass.

Reset
REQ-025 On reset: all valid and dirty bits 0, age of way w = w in every set, evict_valid = 0.
REQ-026 Tag and data arrays SHALL NOT be reset; reset has priority over concurrent wr_en, rd_en, inv_en.
REQ-027 Reset asserted the cycle after a dirty replacement SHALL suppress the pending eviction (evict_valid=0).

Structure
REQ-028 Default parameter values and an age-update/victim-select function prototype SHALL live in shared package cache_pkg.
REQ-029 Per-set LRU age logic (access update, victim index) SHALL be sub-module cachemem_lru, instantiated once per set.

Verification (NUM_SETS=16, NUM_WAYS=2, TAG_W=8, DATA_W=64)
REQ-030 Reset, read idx 3 tag 0x12 -> rd_valid=0, evict_valid=0.
REQ-031 Write idx 3 tag 0x12 data 0xA (clean), next cycle read -> rd_valid=1, rd_data=0xA; write tag 0x34 data 0xB -> both tags hit.
REQ-032 Fill idx 5 with tag 0x01 dirty, tag 0x02 clean, read-hit 0x01, write tag 0x03 -> 0x02 replaced, evict_valid=0; then write 0x04 -> evict_valid=1, evict_tag=0x01, evict_idx=5 for one cycle.
REQ-033 Dirty line idx 7 tag 0x55, inv_en same cycle as wr_en (idx 9) -> invalidate dropped; repeat with wr_en=0 -> rd_valid=0 next cycle, eviction pulse tag 0x55.
REQ-034 Same-cycle read and write idx 2 tag 0x66 new data 0xC over old 0xD -> rd_data=0xD that cycle, 0xC next cycle.
REQ-035 Reset asserted the cycle after a dirty replacement -> evict_valid stays 0, all reads miss afterwards.
